baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_pkg.sv | 13 +
 rtl/baud_gen_frac.sv | 159 +++++++++++++++
 tb/tb_baud_gen_frac.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared types and default sizing for the fractional baud-rate generator.
package baud_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DVSR_W_DEF = 21;
    localparam int FRAC_W_DEF = 4;
    localparam int OVS_DEF    = 16;

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample tick generator: period dvsr_int+1 cycles plus a
// dvsr_frac/2^FRAC_W cycle stretch spread by a phase accumulator.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int DVSR_W = DVSR_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OVS    = OVS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic              load,
    input  logic [DVSR_W-1:0] dvsr_int,
    input  logic [FRAC_W-1:0] dvsr_frac,
    output logic              tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              active,
    output logic              pending
);

    localparam int OVS_W = $clog2(OVS);
    localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

    state_e            state_q, state_d;
    logic [DVSR_W:0]   cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              ext_q, ext_d;
    logic [OVS_W-1:0]  ovs_q, ovs_d;
    logic [DVSR_W-1:0] act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DVSR_W-1:0] sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;
    logic              mid_q, mid_d;
    logic              bit_q, bit_d;

    logic [DVSR_W:0]   limit;
    logic              boundary;
    logic [FRAC_W:0]   frac_sum;
    logic [DVSR_W-1:0] apply_int;
    logic [FRAC_W-1:0] apply_frac;

    assign limit      = {1'b0, act_int_q} + (DVSR_W + 1)'(ext_q);
    assign boundary   = (state_q == RUN) && (cnt_q == limit);
    assign frac_sum   = {1'b0, acc_q} + {1'b0, act_frac_q};
    // A same-cycle load beats whatever is parked in the shadow.
    assign apply_int  = load ? dvsr_int  : sh_int_q;
    assign apply_frac = load ? dvsr_frac : sh_frac_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ext_d      = ext_q;
        ovs_d      = ovs_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        mid_d      = 1'b0;
        bit_d      = 1'b0;

        if (load) begin
            sh_int_d  = dvsr_int;
            sh_frac_d = dvsr_frac;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                acc_d  = '0;
                ext_d  = 1'b0;
                ovs_d  = '0;
                pend_d = 1'b0;
                if (load) begin
                    act_int_d  = dvsr_int;
                    act_frac_d = dvsr_frac;
                end
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en || restart) begin
                    if (!en) state_d = IDLE;
                    cnt_d  = '0;
                    acc_d  = '0;
                    ext_d  = 1'b0;
                    ovs_d  = '0;
                    pend_d = 1'b0;
                    if (load || pend_q) begin
                        act_int_d  = apply_int;
                        act_frac_d = apply_frac;
                    end
                end else if (boundary) begin
                    cnt_d  = '0;
                    {ext_d, acc_d} = frac_sum;
                    ovs_d  = (ovs_q == OVS_LAST) ? '0 : ovs_q + 1'b1;
                    tick_d = 1'b1;
                    mid_d  = (ovs_q == OVS_MID);
                    bit_d  = (ovs_q == OVS_LAST);
                    pend_d = 1'b0;
                    if (load || pend_q) begin
                        act_int_d  = apply_int;
                        act_frac_d = apply_frac;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (load) pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            ext_q      <= 1'b0;
            ovs_q      <= '0;
            act_int_q  <= '0;
            act_frac_q <= '0;
            sh_int_q   <= '0;
            sh_frac_q  <= '0;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            mid_q      <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ext_q      <= ext_d;
            ovs_q      <= ovs_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            mid_q      <= mid_d;
            bit_q      <= bit_d;
        end
    end

    assign tick     = tick_q;
    assign mid_tick = mid_q;
    assign bit_tick = bit_q;
    assign active   = (state_q == RUN);
    assign pending  = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: closed-form tick-time model plus directed
// load/restart/reset scenarios.
module tb_baud_gen_frac;

    localparam int DW  = 21;
    localparam int FW  = 4;
    localparam int OVS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          restart = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] dvsr_int = '0;
    logic [FW-1:0] dvsr_frac = '0;
    logic          tick, mid_tick, bit_tick, active, pending;

    int n_pass = 0;
    int n_chk  = 0;

    baud_gen_frac #(.DVSR_W(DW), .FRAC_W(FW), .OVS(OVS)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .restart   (restart),
        .load      (load),
        .dvsr_int  (dvsr_int),
        .dvsr_frac (dvsr_frac),
        .tick      (tick),
        .mid_tick  (mid_tick),
        .bit_tick  (bit_tick),
        .active    (active),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Edge (counted from the start edge) of the k-th tick: k whole periods
    // plus the integer part of the fractional phase accrued before it.
    function automatic int texp(input int k, input int d, input int f);
        return k * (d + 1) + (((k - 1) * f) >> FW);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_case(input int d, input int f, input int nt, input int r);
        int e, base, k, t1, t17;
        logic et;
        dvsr_int = DW'(d);
        dvsr_frac = FW'(f);
        load = 1'b1;
        step();
        load = 1'b0;
        chk("pend_idle", pending, 0);
        en = 1'b1;
        e = -1;
        base = 0;
        k = 1;
        t1 = 0;
        t17 = 0;
        while (k <= nt && e < 4000) begin
            restart = (e + 1 == r);
            step();
            e++;
            restart = 1'b0;
            if (e == r) begin
                base = r;
                k = 1;
            end
            et = (e == base + texp(k, d, f));
            chk("tick", tick, et);
            chk("mid", mid_tick, et && ((k - 1) % OVS == OVS / 2 - 1));
            chk("bit", bit_tick, et && ((k - 1) % OVS == OVS - 1));
            chk("active", active, 1);
            if (et) begin
                if (k == 1) t1 = e;
                if (k == 17) t17 = e;
                k++;
            end
        end
        chk("nticks", k - 1, nt);
        if (nt >= 17 && r < 0) chk("span16", t17 - t1, 16 * (d + 1) + f);
        en = 1'b0;
        step();
        chk("idle_act", active, 0);
        chk("idle_tick", tick, 0);
        step();
    endtask

    task automatic directed_load();
        int exp_q[$];
        int e;
        logic et;
        exp_q = '{10, 15, 20, 25, 28, 31, 40, 47};
        dvsr_int = DW'(9);
        dvsr_frac = '0;
        load = 1'b1;
        step();
        load = 1'b0;
        en = 1'b1;
        e = -1;
        while (e < 50) begin
            load = (e + 1 == 4) || (e + 1 == 25) || (e + 1 == 33);
            restart = (e + 1 == 33);
            if (e + 1 == 4) dvsr_int = DW'(4);
            if (e + 1 == 25) dvsr_int = DW'(2);
            if (e + 1 == 33) dvsr_int = DW'(6);
            step();
            e++;
            load = 1'b0;
            restart = 1'b0;
            et = (exp_q.size() > 0) && (e == exp_q[0]);
            if (et) void'(exp_q.pop_front());
            chk("ld_tick", tick, et);
            chk("ld_pend", pending, (e >= 4 && e <= 9));
        end
        chk("ld_left", exp_q.size(), 0);
        en = 1'b0;
        step();
        step();
    endtask

    task automatic reset_case();
        dvsr_int = DW'(9);
        dvsr_frac = FW'(3);
        load = 1'b1;
        step();
        load = 1'b0;
        en = 1'b1;
        repeat (5) step();
        dvsr_int = DW'(3);
        load = 1'b1;
        step();
        load = 1'b0;
        chk("rst_pre_pend", pending, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_tick", tick, 0);
        chk("rst_act", active, 0);
        chk("rst_pend", pending, 0);
        chk("rst_outs", {mid_tick, bit_tick}, 0);
        en = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_act", active, 0);
        end
        en = 1'b1;
        step();
        chk("zero_t0", tick, 0);
        chk("zero_a0", active, 1);
        repeat (5) begin
            step();
            chk("zero_tick", tick, 1);
            chk("zero_pend", pending, 0);
        end
        en = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_tick", tick, 0);
        chk("reset_mid", mid_tick, 0);
        chk("reset_bit", bit_tick, 0);
        chk("reset_act", active, 0);
        chk("reset_pend", pending, 0);
        step();
        reset = 1'b0;
        step();
        chk("idle_act0", active, 0);

        run_case(9, 0, 20, -1);
        run_case(9, 8, 17, -1);
        run_case(0, 0, 20, -1);
        run_case(1, 0, 32, -1);
        run_case(9, 0, 5, 17);
        for (int i = 0; i < 10; i++) begin
            int d, f, nt, r;
            d = int'($urandom_range(0, 12));
            f = int'($urandom_range(0, 15));
            nt = int'($urandom_range(17, 40));
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 120)) : -1;
            run_case(d, f, nt, r);
        end
        directed_load();
        reset_case();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
